asrm_alu_seq: RTL and testbench

Multi-cycle, width-parametrised ALU for the asrm core, the successor of the single-cycle combinational ALU. It keeps the same opcode set, working/other/status register operands and out/out_reg result routing. It adds real logical shifts, a corrected bitwise NOT and an optional iterative multiplier. It sits between the register file and the control unit; the control unit stalls on `busy` and writes back `out` into register `out_reg` when `done` pulses.

---
 rtl/asrm_alu_seq_if.sv | 20 ++
 rtl/asrm_alu_seq.sv | 150 +++++++++++++++
 tb/tb_asrm_alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/asrm_alu_seq_if.sv
// asrm_alu_seq_if: request/result bundle between the control unit (master) and the ALU (slave).
interface asrm_alu_seq_if #(parameter int wordsize = 16);
    logic                start;
    logic [7:0]          instruction;
    logic [wordsize-1:0] working_register;
    logic [wordsize-1:0] other_register;
    logic [wordsize-1:0] status_register;
    logic                busy;
    logic                done;
    logic [wordsize-1:0] out;
    logic [3:0]          out_reg;
    modport master (
        output start, instruction, working_register, other_register, status_register,
        input  busy, done, out, out_reg
    );
    modport slave (
        input  start, instruction, working_register, other_register, status_register,
        output busy, done, out, out_reg
    );
endinterface

// File: rtl/asrm_alu_seq.sv
// asrm_alu_seq: multi-cycle ALU with iterative shifts; ASRM_ALU_MUL_EN adds a shift-add multiplier.
module asrm_alu_seq #(
    parameter int wordsize = 16
) (
    input logic           clk,
    input logic           reset,
    asrm_alu_seq_if.slave bus
);
    localparam int cw = $clog2(wordsize) + 1;
    localparam logic [3:0] opp_add = 4'h0;
    localparam logic [3:0] opp_sub = 4'h1;
    localparam logic [3:0] opp_and = 4'h2;
    localparam logic [3:0] opp_or  = 4'h3;
    localparam logic [3:0] opp_xor = 4'h4;
    localparam logic [3:0] opp_not = 4'h5;
    localparam logic [3:0] opp_lsl = 4'h6;
    localparam logic [3:0] opp_lsr = 4'h7;
    localparam logic [3:0] opp_eq  = 4'h8;
    localparam logic [3:0] opp_les = 4'h9;
`ifdef ASRM_ALU_MUL_EN
    localparam logic [3:0] opp_mul = 4'hA;
`endif
    localparam logic [7:0] inst_slp = 8'hFF;
    localparam logic [3:0] sr_id    = 4'hF;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [wordsize-1:0] out_q, out_d;
    logic [3:0]          out_reg_q, out_reg_d;
    logic [wordsize-1:0] acc_q, acc_d;
    logic [cw-1:0]       cnt_q, cnt_d;
    logic                lsr_q, lsr_d;
`ifdef ASRM_ALU_MUL_EN
    logic [wordsize-1:0] b_q, b_d;
    logic [wordsize-1:0] prod_q, prod_d;
`endif

    logic [wordsize-1:0] a, b, sr, sr_hi;
    logic [cw-1:0]       amt;

    assign a     = bus.working_register;
    assign b     = bus.other_register;
    assign sr    = bus.status_register;
    // compare result replaces SR bit 0, the rest of SR passes through
    assign sr_hi = sr & ~wordsize'(1);
    assign amt   = (b >= wordsize'(wordsize)) ? cw'(wordsize) : b[cw-1:0];

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_reg_d = out_reg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        lsr_d     = lsr_q;
`ifdef ASRM_ALU_MUL_EN
        b_d       = b_q;
        prod_d    = prod_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = DONE;
                out_reg_d = 4'h0;
                if (bus.instruction == inst_slp) out_d = a;
                else case (bus.instruction[7:4])
                    opp_add: out_d = a + b;
                    opp_sub: out_d = a - b;
                    opp_and: out_d = a & b;
                    opp_or:  out_d = a | b;
                    opp_xor: out_d = a ^ b;
                    opp_not: out_d = ~b;
                    opp_eq: begin
                        out_d     = sr_hi | wordsize'(a == b);
                        out_reg_d = sr_id;
                    end
                    opp_les: begin
                        out_d     = sr_hi | wordsize'(a < b);
                        out_reg_d = sr_id;
                    end
                    opp_lsl, opp_lsr: begin
                        acc_d   = a;
                        cnt_d   = amt;
                        lsr_d   = bus.instruction[7:4] == opp_lsr;
                        state_d = SHIFT;
                    end
`ifdef ASRM_ALU_MUL_EN
                    opp_mul: begin
                        acc_d   = a;
                        b_d     = b;
                        prod_d  = '0;
                        cnt_d   = cw'(wordsize);
                        state_d = MUL;
                    end
`endif
                    default: out_d = '0;
                endcase
            end
            SHIFT: if (cnt_q == '0) begin
                out_d   = acc_q;
                state_d = DONE;
            end else begin
                acc_d = lsr_q ? acc_q >> 1 : acc_q << 1;
                cnt_d = cnt_q - 1'b1;
            end
`ifdef ASRM_ALU_MUL_EN
            MUL: if (cnt_q == '0) begin
                out_d   = prod_q;
                state_d = DONE;
            end else begin
                prod_d = prod_q + (b_q[0] ? acc_q : '0);
                acc_d  = acc_q << 1;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q - 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            out_q     <= '0;
            out_reg_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            lsr_q     <= 1'b0;
`ifdef ASRM_ALU_MUL_EN
            b_q       <= '0;
            prod_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_reg_q <= out_reg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            lsr_q     <= lsr_d;
`ifdef ASRM_ALU_MUL_EN
            b_q       <= b_d;
            prod_q    <= prod_d;
`endif
        end
    end

    assign bus.busy    = state_q != IDLE;
    assign bus.done    = state_q == DONE;
    assign bus.out     = out_q;
    assign bus.out_reg = out_reg_q;
endmodule

// File: tb/tb_asrm_alu_seq.sv
// tb_asrm_alu_seq: scoreboard bench; driver queues expected results, monitor checks each done pulse.
module tb_asrm_alu_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [15:0] o;
        logic [3:0]  r;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sb[$];

    asrm_alu_seq_if #(.wordsize(16)) bus();
    asrm_alu_seq #(.wordsize(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", 32'(bus.out), 32'(e.o));
                chk("out_reg", 32'(bus.out_reg), 32'(e.r));
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic drive(input logic [7:0] ins, input logic [15:0] a, input logic [15:0] b, input logic [15:0] sr);
        bus.start            = 1'b1;
        bus.instruction      = ins;
        bus.working_register = a;
        bus.other_register   = b;
        bus.status_register  = sr;
    endtask

    task automatic issue(input logic [7:0] ins, input logic [15:0] a, input logic [15:0] b, input logic [15:0] sr,
                         input logic [15:0] eo, input logic [3:0] er, input int lat, input int hold);
        exp_t e;
        @(negedge clk);
        e.o = eo; e.r = er; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        drive(ins, a, b, sr);
        repeat (hold) @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic run(input logic [7:0] ins, input logic [15:0] a, input logic [15:0] b, input logic [15:0] sr,
                       input logic [15:0] eo, input logic [3:0] er, input int lat);
        issue(ins, a, b, sr, eo, er, lat, 1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(8'h00, 16'h1111, 16'h2222, 16'h0000);
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_out", 32'(bus.out), 32'd0);
            chk("rst_out_reg", 32'(bus.out_reg), 32'd0);
        end
        bus.start = 1'b0;
        reset = 1'b1;
        run(8'h00, 16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 4'h0, 1);
        run(8'h80, 16'h1234, 16'h1234, 16'hABCC, 16'hABCD, 4'hF, 1);
        run(8'h90, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 4'hF, 1);
        run(8'h90, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFF, 4'hF, 1);
        run(8'h10, 16'h0010, 16'h0001, 16'h0000, 16'h000F, 4'h0, 1);
        run(8'h20, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030, 4'h0, 1);
        run(8'h30, 16'hF0F0, 16'h3C3C, 16'h0000, 16'hFCFC, 4'h0, 1);
        run(8'h40, 16'hF0F0, 16'h3C3C, 16'h0000, 16'hCCCC, 4'h0, 1);
        run(8'hFF, 16'hBEEF, 16'h1234, 16'h0000, 16'hBEEF, 4'h0, 1);
        run(8'hB0, 16'hBEEF, 16'h1234, 16'h0000, 16'h0000, 4'h0, 1);
        run(8'hF0, 16'hBEEF, 16'h1234, 16'h0000, 16'h0000, 4'h0, 1);
        run(8'h60, 16'h0001, 16'd4, 16'h0000, 16'h0010, 4'h0, 6);
        run(8'h70, 16'h8000, 16'd15, 16'h0000, 16'h0001, 4'h0, 17);
        run(8'h60, 16'h5A5A, 16'd0, 16'h0000, 16'h5A5A, 4'h0, 2);
        run(8'h70, 16'hFFFF, 16'd40, 16'h0000, 16'h0000, 4'h0, 18);
        issue(8'h60, 16'h00A5, 16'd8, 16'h0000, 16'hA500, 4'h0, 10, 1);
        for (int i = 0; i < 9; i++) begin
            drive(8'h00 | 8'(i << 4), 16'($urandom), 16'($urandom), 16'($urandom));
            bus.start = i[0];
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done();
        issue(8'h50, 16'h1234, 16'h00F0, 16'h0000, 16'hFF0F, 4'h0, 1, 2);
        wait_done();
        @(negedge clk);
        drive(8'h60, 16'h0001, 16'd10, 16'h0000);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_out", 32'(bus.out), 32'd0);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_idle_out", 32'(bus.out), 32'd0);
        run(8'h10, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 4'h0, 1);
`ifdef ASRM_ALU_MUL_EN
        run(8'hA0, 16'd300, 16'd300, 16'h0000, 16'h5F90, 4'h0, 18);
`else
        run(8'hA0, 16'd300, 16'd300, 16'h0000, 16'h0000, 4'h0, 1);
`endif
        repeat (4) @(negedge clk);
        chk("final_idle_busy", 32'(bus.busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
